// File: rtl/axi4l_master_arbiter.sv
// axi4l_master_arbiter
// Two-requester AXI4-Lite master. Round-robin arbitration, one outstanding
// transaction, fully registered outputs. Requester 0 is GPIO config/sequencing,
// requester 1 is the debug/host path; both share a single AXI4-Lite port.

module axi4l_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  // requester side
  input  logic [1:0]                    req,
  input  logic [1:0]                    we,
  input  logic [2*ADDR_WIDTH-1:0]       addr,
  input  logic [2*DATA_WIDTH-1:0]       wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]   wstrb,
  output logic [1:0]                    ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    resp,
  output logic                          busy,
  output logic                          gnt_id,
  // AXI4-Lite master port
  output logic [ADDR_WIDTH-1:0]         AWADDR,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [DATA_WIDTH-1:0]         WDATA,
  output logic [DATA_WIDTH/8-1:0]       WSTRB,
  output logic                          WVALID,
  input  logic                          WREADY,
  input  logic                          BVALID,
  input  logic [1:0]                    BRESP,
  output logic                          BREADY,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic                          RVALID,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  input  logic [1:0]                    RRESP,
  output logic                          RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    DONE         = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    busy_q, busy_d;
  logic                    gnt_id_q, gnt_id_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;

  logic                    winner_s;
  logic                    aw_done_s;
  logic                    w_done_s;
  logic [1:0]              ack_onehot_s;

  // Arbitration: a lone request wins outright; on a tie the requester that
  // was not granted last time wins.
  always_comb begin
    winner_s = 1'b0;
    if (req == 2'b11) begin
      winner_s = ~gnt_id_q;
    end else begin
      winner_s = req[1];
    end
  end

  // Write-channel progress: a channel is done once its VALID has been taken
  // down, or is being accepted in this very cycle.
  always_comb begin
    aw_done_s    = (~awvalid_q) | AWREADY;
    w_done_s     = (~wvalid_q) | WREADY;
    ack_onehot_s = gnt_id_q ? 2'b10 : 2'b01;
  end

  // Next-state and next-output logic; every output is computed here and
  // registered below so nothing reaches a port combinationally.
  always_comb begin
    state_d   = state_q;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    gnt_id_d  = gnt_id_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_id_d = winner_s;
          if (we[winner_s]) begin
            awaddr_d  = winner_s ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
            wdata_d   = winner_s ? wdata[DATA_WIDTH +: DATA_WIDTH] : wdata[0 +: DATA_WIDTH];
            wstrb_d   = winner_s ? wstrb[STRB_WIDTH +: STRB_WIDTH] : wstrb[0 +: STRB_WIDTH];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            araddr_d  = winner_s ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WR_ADDR_DATA: begin
        if (awvalid_q && AWREADY) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && WREADY) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_done_s && w_done_s) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          state_d = WR_ADDR_DATA;
        end
      end

      WR_RESP: begin
        if (BVALID) begin
          bready_d = 1'b0;
          resp_d   = BRESP;
          rdata_d  = {DATA_WIDTH{1'b0}};
          ack_d    = ack_onehot_s;
          state_d  = DONE;
        end else begin
          state_d = WR_RESP;
        end
      end

      RD_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end

      RD_DATA: begin
        if (RVALID) begin
          rready_d = 1'b0;
          rdata_d  = RDATA;
          resp_d   = RRESP;
          ack_d    = ack_onehot_s;
          state_d  = DONE;
        end else begin
          state_d = RD_DATA;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset; a reset
  // mid-transaction drops every handshake line and suppresses the ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ack_q     <= 2'b00;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      resp_q    <= 2'b00;
      busy_q    <= 1'b0;
      gnt_id_q  <= 1'b1;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      awvalid_q <= 1'b0;
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_WIDTH{1'b0}};
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= {ADDR_WIDTH{1'b0}};
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      busy_q    <= busy_d;
      gnt_id_q  <= gnt_id_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign resp    = resp_q;
  assign busy    = busy_q;
  assign gnt_id  = gnt_id_q;
  assign AWADDR  = awaddr_q;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

endmodule

// File: doc/axi4l_master_arbiter.md
# axi4l_master_arbiter

Two-requester AXI4-Lite master that arbitrates register accesses onto one AXI4-Lite bus. It sits between the GPIO configuration/sequencing logic (requester 0) and the debug/host access path (requester 1) on one side and the GPIO register slave on the other. Only one transaction is outstanding at a time. Requesters are served round-robin.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  2  per-requester request, level; bit i = requester i.
- we  in  2  per-requester direction: 1 = write, 0 = read.
- addr  in  2*ADDR_WIDTH  per-requester address; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  2*DATA_WIDTH  per-requester write data.
- wstrb  in  2*DATA_WIDTH/8  per-requester write strobes.
- ack  out  2  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_WIDTH  read data; valid only while an ack bit is high.
- resp  out  2  BRESP/RRESP of the completed transaction; valid only while an ack bit is high.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  index of the current/last granted requester.
- AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY  out; AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP  in. Widths per AXI4-Lite with ADDR_WIDTH/DATA_WIDTH.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: samples req. If no bit is set, stays in IDLE. If one bit is set, grants it. If both are set, grants the requester other than gnt_id (round-robin). On grant:
  - Registers addr, wdata, wstrb and we of the winner.
  - Updates gnt_id.
  - Moves to WR_ADDR_DATA (we=1) or RD_ADDR (we=0).
- WR_ADDR_DATA:
  - AWVALID and WVALID assert together.
  - Each deasserts independently on the edge where its own READY is seen high.
  - Moves to WR_RESP once both handshakes are done, including the case where both complete in the same cycle.
- WR_RESP: BREADY=1. On BVALID, captures BRESP into resp, sets rdata=0 and goes to DONE.
- RD_ADDR: ARVALID=1 until ARREADY, then goes to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, captures RDATA and RRESP and goes to DONE.
- DONE:
  - ack[gnt_id]=1 for exactly this one cycle, then returns to IDLE.
  - rdata and resp hold until the next DONE.
- Requester rules:
  - The command is captured at grant. Changes to inputs after grant are ignored.
  - Dropping req after grant does not abort the transaction; ack still pulses.
  - A requester must drop req on the edge after seeing ack. A req still high in IDLE starts a new transaction.
- Strobes and data are passed unmodified. resp values other than OKAY (SLVERR, DECERR) are reported and do not cause a retry.
- No timeout. A slave that never responds holds the block in its current state until reset.

## Timing
- Reset (rst=0 at a rising edge):
  - All AXI VALID/READY outputs go to 0; ack=0, busy=0, rdata=0, resp=0, gnt_id=1, state=IDLE.
  - With gnt_id=1, requester 0 wins the first simultaneous request.
  - AWADDR, WDATA, WSTRB and ARADDR go to 0.
- Reset mid-transaction aborts immediately. No ack is issued, and VALID/READY are low in the first cycle after the reset edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Zero-wait slave, write: req sampled at edge 0 → AWVALID/WVALID high in cycle 1 → BREADY high in cycle 2 → ack high in cycle 3. Read has the same shape (ARVALID cycle 1, RREADY cycle 2, ack cycle 3).
- Back-to-back: the next grant occurs at the earliest in the IDLE cycle after DONE, giving a 4-cycle minimum turnaround per transaction.
- VALID, once asserted, stays high until its handshake completes, per AXI rules.

## Test plan
- Single write, zero-wait slave:
  - Stimulus: req=01, we=01, addr0=0x10, wdata0=0xA5A5_0001, wstrb0=0xF.
  - Required: AWADDR=0x10 and WDATA match in cycle 1; ack=01 in cycle 3; resp=0.
- Read with delays:
  - Stimulus: req=10, we=00, addr1=0x04; ARREADY delayed 2 cycles; RVALID 3 cycles later with RDATA=0xDEAD_BEEF, RRESP=0.
  - Required: ARVALID holds for 3 cycles; ack=10 with rdata=0xDEAD_BEEF.
- Simultaneous requests held high across 4 transactions:
  - Required: grant order 0,1,0,1; gnt_id toggles; each ack goes only to its own requester.
- Split write handshakes:
  - Stimulus: AWREADY in cycle 1, WREADY in cycle 4.
  - Required: AWVALID low from cycle 2; WVALID high through cycle 4; BREADY from cycle 5.
- Error response:
  - Stimulus: BRESP=2'b10 on a write.
  - Required: resp=2'b10 with the ack pulse; the next transaction proceeds normally.
- Reset in RD_DATA:
  - Stimulus: rst=0 while RREADY=1.
  - Required: RREADY=0, busy=0, ack never pulses; the next request after reset is granted to requester 0.
